// File: rtl/sync_ram_dp.sv
// Simple dual-port synchronous RAM with byte-enable writes and configurable read-during-write.
// Has an optional output register and a clear sweep that runs after reset or on request.
module sync_ram_dp #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 4,
   parameter int                    RDW_MODE    = 0,
   parameter int                    OUT_REG     = 0,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear_req,
   output logic                    init_busy,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    rvalid
);

   localparam int DEPTH  = 2**ADDR_WIDTH;
   localparam int NBYTES = DATA_WIDTH/8;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   ptr, ptr_nxt;
   logic                    accept;
   logic                    wr_en, rd_en;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // A clear request wins over any access presented in the same cycle.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      accept    = 1'b0;
      case (state)
         ST_CLEAR: begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == LAST_ADDR) state_nxt = ST_READY;
         end
         ST_READY: begin
            if (clear_req) begin
               state_nxt = ST_CLEAR;
               ptr_nxt   = '0;
            end else begin
               accept = 1'b1;
            end
         end
      endcase
   end

   assign init_busy = (state == ST_CLEAR);
   assign wr_en     = accept & we;
   assign rd_en     = accept & re;

   // In new-data mode, enabled bytes of a same-address write bypass the array.
   always_comb begin
      rd_word = mem[raddr];
      if (RDW_MODE != 0 && wr_en && (waddr == raddr)) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wbe[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (init_busy) begin
         mem[ptr] <= CLEAR_VALUE;
      end else if (wr_en) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // re/rvalid contract: each accepted re yields exactly one rvalid pulse at the
   // configured latency; rdata holds its last value between pulses.
   generate
      if (OUT_REG == 0) begin : g_direct
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rdata  <= '0;
               rvalid <= 1'b0;
            end else begin
               rvalid <= rd_en;
               if (rd_en) rdata <= rd_word;
            end
         end
      end else begin : g_outreg
         logic [DATA_WIDTH-1:0] s1_data;
         logic                  s1_valid;

         // The second stage keeps draining during a sweep so an issued read completes.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_data  <= '0;
               s1_valid <= 1'b0;
               rdata    <= '0;
               rvalid   <= 1'b0;
            end else begin
               s1_valid <= rd_en;
               if (rd_en) s1_data <= rd_word;
               rvalid <= s1_valid;
               if (s1_valid) rdata <= s1_data;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_ram_dp.sv
// Bench for sync_ram_dp: a 32-bit old-data/direct instance and an 8-bit new-data/registered
// instance share stimulus and are compared against a behavioural reference model.
module tb_sync_ram_dp;

   localparam int          DEPTH = 16;
   localparam logic [31:0] CV0   = 32'hA5A5_A5A5;
   localparam logic [7:0]  CV1   = 8'hA5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clear_req = 1'b0, we = 1'b0, re = 1'b0;
   logic [3:0]  waddr = '0, raddr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wbe = '0;
   logic [31:0] rdata0;
   logic        rvalid0, busy0;
   logic [7:0]  rdata1;
   logic        rvalid1, busy1;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   sync_ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(0), .OUT_REG(0), .CLEAR_VALUE(CV0)) u0 (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_busy(busy0),
      .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0));

   sync_ram_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RDW_MODE(1), .OUT_REG(1), .CLEAR_VALUE(CV1)) u1 (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_busy(busy1),
      .we(we), .waddr(waddr), .wdata(wdata[7:0]), .wbe(wbe[0:0]),
      .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1));

   // Reference model: array contents, remaining sweep edges, and due-time queues of reads.
   typedef struct { int due; logic [31:0] d; } rd_t;
   rd_t         q0[$];
   rd_t         q1[$];
   logic [31:0] m0 [DEPTH];
   logic [7:0]  m1 [DEPTH];
   int          busy_left = DEPTH;
   int          cyc = 0;
   logic        e_rv0 = 1'b0, e_rv1 = 1'b0;
   logic [31:0] e_rd0 = '0;
   logic [7:0]  e_rd1 = '0;
   logic [31:0] o0;
   logic [7:0]  o1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_left = DEPTH;
         q0.delete();
         q1.delete();
         e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
      end else begin
         cyc++;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               for (int a = 0; a < DEPTH; a++) begin
                  m0[a] = CV0;
                  m1[a] = CV1;
               end
            end
         end else if (clear_req) begin
            busy_left = DEPTH;
         end else begin
            if (re) begin
               o0 = m0[raddr];
               o1 = m1[raddr];
               if (we && wbe[0] && waddr == raddr) o1 = wdata[7:0];
               q0.push_back('{cyc, o0});
               q1.push_back('{cyc + 1, {24'h0, o1}});
            end
            if (we) begin
               for (int b = 0; b < 4; b++) if (wbe[b]) m0[waddr][8*b +: 8] = wdata[8*b +: 8];
               if (wbe[0]) m1[waddr] = wdata[7:0];
            end
         end
         e_rv0 = 1'b0;
         if (q0.size() > 0 && q0[0].due == cyc) begin
            e_rv0 = 1'b1; e_rd0 = q0[0].d; void'(q0.pop_front());
         end
         e_rv1 = 1'b0;
         if (q1.size() > 0 && q1[0].due == cyc) begin
            e_rv1 = 1'b1; e_rd1 = q1[0].d[7:0]; void'(q1.pop_front());
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic exp_busy;
      #2 rst_n = 1'b0;
      repeat (2) cycle();
      checks++;
      if ({rvalid0, rvalid1, busy0, busy1, rdata0, rdata1} !== {1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 8'h0}) begin
         errors++;
         $display("FAIL reset_outputs: got rv=%b%b busy=%b%b rd=%h/%h expected rv=00 busy=11 rd=0/0",
                  rvalid0, rvalid1, busy0, busy1, rdata0, rdata1);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= DEPTH; k++) begin
         cycle();
         exp_busy = (k < DEPTH);
         checks++;
         if ({busy0, busy1} !== {2{exp_busy}}) begin
            errors++;
            $display("FAIL reset_busy edge %0d: got %b%b expected %b", k, busy0, busy1, exp_busy);
         end
      end
      for (int i = 0; i < DEPTH + 2; i++) begin
         re = (i < DEPTH);
         raddr = 4'(i);
         cycle();
         checks++;
         if ({rvalid0, rdata0, rvalid1, rdata1} !== {e_rv0, e_rd0, e_rv1, e_rd1}) begin
            errors++;
            $display("FAIL sweep_read %0d: got %b %h %b %h expected %b %h %b %h", i,
                     rvalid0, rdata0, rvalid1, rdata1, e_rv0, e_rd0, e_rv1, e_rd1);
         end
         if (i < DEPTH) begin
            checks++;
            if (rvalid0 !== 1'b1 || rdata0 !== CV0) begin
               errors++;
               $display("FAIL sweep_value %0d: got %b %h expected 1 %h", i, rvalid0, rdata0, CV0);
            end
         end
      end
      re = 1'b0;
   endtask

   task automatic test_byte_enable();
      we = 1'b1; waddr = 4'd3; wdata = 32'h1122_3344; wbe = 4'hF;
      cycle();
      wdata = 32'hAABB_CCDD; wbe = 4'b0101;
      cycle();
      wdata = 32'hFFFF_FFFF; wbe = 4'b0000;
      cycle();
      we = 1'b0; re = 1'b1; raddr = 4'd3;
      cycle();
      re = 1'b0;
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'h11BB_33DD) begin
         errors++;
         $display("FAIL byte_enable32: got %b %h expected 1 11bb33dd", rvalid0, rdata0);
      end
      cycle();
      checks++;
      if (rvalid1 !== 1'b1 || rdata1 !== 8'hDD || rvalid0 !== 1'b0) begin
         errors++;
         $display("FAIL byte_enable8: got rv1=%b rd1=%h rv0=%b expected 1 dd 0", rvalid1, rdata1, rvalid0);
      end
   endtask

   task automatic test_rdw();
      we = 1'b1; waddr = 4'd5; wdata = 32'h0000_0001; wbe = 4'hF;
      cycle();
      wdata = 32'h0000_007E; re = 1'b1; raddr = 4'd5;
      cycle();
      we = 1'b0;
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'h0000_0001) begin
         errors++;
         $display("FAIL rdw_old: got %b %h expected 1 00000001", rvalid0, rdata0);
      end
      cycle();
      re = 1'b0;
      checks++;
      if (rdata0 !== 32'h0000_007E || rvalid1 !== 1'b1 || rdata1 !== 8'h7E) begin
         errors++;
         $display("FAIL rdw_new: got rd0=%h rv1=%b rd1=%h expected 0000007e 1 7e", rdata0, rvalid1, rdata1);
      end
      cycle();
      checks++;
      if (rvalid1 !== 1'b1 || rdata1 !== 8'h7E) begin
         errors++;
         $display("FAIL rdw_after: got %b %h expected 1 7e", rvalid1, rdata1);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v [3];
      for (int i = 0; i < 3; i++) begin
         v[i] = $urandom;
         we = 1'b1; waddr = 4'(i); wdata = v[i]; wbe = 4'hF;
         cycle();
      end
      we = 1'b0;
      for (int i = 0; i < 6; i++) begin
         re = (i < 3);
         raddr = 4'(i);
         cycle();
         checks++;
         if (rvalid0 !== (i < 3) || (i < 3 && rdata0 !== v[i])) begin
            errors++;
            $display("FAIL b2b_direct %0d: got %b %h expected %b %h", i, rvalid0, rdata0, (i < 3), v[i % 3]);
         end
         checks++;
         if (rvalid1 !== (i >= 1 && i <= 3) || (i >= 1 && i <= 3 && rdata1 !== v[(i + 2) % 3][7:0])) begin
            errors++;
            $display("FAIL b2b_outreg %0d: got %b %h expected %b %h", i, rvalid1, rdata1,
                     (i >= 1 && i <= 3), v[(i + 2) % 3][7:0]);
         end
      end
      re = 1'b0;
   endtask

   task automatic test_clear();
      we = 1'b1; waddr = 4'd9; wdata = 32'h1234_5678; wbe = 4'hF;
      cycle();
      we = 1'b0; re = 1'b1; raddr = 4'd9;
      cycle();
      re = 1'b0; clear_req = 1'b1; we = 1'b1; waddr = 4'd9; wdata = 32'h0000_0055; wbe = 4'hF;
      cycle();
      checks++;
      if ({busy0, busy1, rvalid0, rvalid1, rdata1} !== {1'b1, 1'b1, 1'b0, 1'b1, 8'h78}) begin
         errors++;
         $display("FAIL clear_start: got busy=%b%b rv=%b%b rd1=%h expected busy=11 rv=01 rd1=78",
                  busy0, busy1, rvalid0, rvalid1, rdata1);
      end
      clear_req = 1'b0; we = 1'b0; re = 1'b1;
      for (int k = 1; k <= DEPTH; k++) begin
         raddr = 4'($urandom_range(0, DEPTH - 1));
         cycle();
         checks++;
         if ({rvalid0, rvalid1, busy0, busy1} !== {1'b0, 1'b0, {2{k < DEPTH}}}) begin
            errors++;
            $display("FAIL clear_sweep edge %0d: got rv=%b%b busy=%b%b expected rv=00 busy=%b",
                     k, rvalid0, rvalid1, busy0, busy1, (k < DEPTH));
         end
      end
      raddr = 4'd9;
      cycle();
      re = 1'b0;
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== CV0) begin
         errors++;
         $display("FAIL clear_dropped32: got %b %h expected 1 %h", rvalid0, rdata0, CV0);
      end
      cycle();
      checks++;
      if (rvalid1 !== 1'b1 || rdata1 !== CV1) begin
         errors++;
         $display("FAIL clear_dropped8: got %b %h expected 1 %h", rvalid1, rdata1, CV1);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         clear_req = ($urandom_range(0, 79) == 0);
         we    = 1'($urandom_range(0, 1));
         re    = 1'($urandom_range(0, 1));
         waddr = 4'($urandom_range(0, DEPTH - 1));
         raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, DEPTH - 1));
         wdata = $urandom;
         wbe   = 4'($urandom_range(0, 15));
         cycle();
         checks++;
         if ({rvalid0, rdata0, rvalid1, rdata1, busy0, busy1} !==
             {e_rv0, e_rd0, e_rv1, e_rd1, {2{busy_left > 0}}}) begin
            errors++;
            $display("FAIL random %0d: got %b %h %b %h %b%b expected %b %h %b %h %b", n,
                     rvalid0, rdata0, rvalid1, rdata1, busy0, busy1,
                     e_rv0, e_rd0, e_rv1, e_rd1, (busy_left > 0));
         end
      end
      clear_req = 1'b0; we = 1'b0; re = 1'b0;
      repeat (DEPTH + 2) cycle();
   endtask

   task automatic test_reset_mid_sweep();
      re = 1'b1; raddr = 4'd9;
      cycle();
      re = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rvalid0, rvalid1, busy0, busy1, rdata0, rdata1} !== {1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 8'h0}) begin
         errors++;
         $display("FAIL reset_inflight: got rv=%b%b busy=%b%b rd=%h/%h expected rv=00 busy=11 rd=0/0",
                  rvalid0, rvalid1, busy0, busy1, rdata0, rdata1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= DEPTH; k++) begin
         cycle();
         checks++;
         if ({rvalid1, busy0, busy1} !== {1'b0, {2{k < DEPTH}}}) begin
            errors++;
            $display("FAIL inflight_lost edge %0d: got rv1=%b busy=%b%b expected 0 %b", k, rvalid1, busy0, busy1, (k < DEPTH));
         end
      end
      re = 1'b1; raddr = 4'd4;
      cycle();
      re = 1'b0; clear_req = 1'b1;
      cycle();
      clear_req = 1'b0;
      repeat (7) cycle();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rvalid0, rvalid1, busy0, busy1, rdata0, rdata1} !== {1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 8'h0}) begin
         errors++;
         $display("FAIL reset_mid_sweep: got rv=%b%b busy=%b%b rd=%h/%h expected rv=00 busy=11 rd=0/0",
                  rvalid0, rvalid1, busy0, busy1, rdata0, rdata1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= DEPTH; k++) begin
         cycle();
         checks++;
         if ({busy0, busy1} !== {2{k < DEPTH}}) begin
            errors++;
            $display("FAIL restart_busy edge %0d: got %b%b expected %b", k, busy0, busy1, (k < DEPTH));
         end
      end
      re = 1'b1; raddr = 4'd12;
      cycle();
      re = 1'b0;
      cycle();
      checks++;
      if (rdata0 !== CV0 || rvalid1 !== 1'b1 || rdata1 !== CV1) begin
         errors++;
         $display("FAIL restart_value: got rd0=%h rv1=%b rd1=%h expected %h 1 %h", rdata0, rvalid1, rdata1, CV0, CV1);
      end
   endtask

   initial begin
      test_reset();
      test_byte_enable();
      test_rdw();
      test_back_to_back();
      test_clear();
      test_random();
      test_reset_mid_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
